seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode 7-segment display. Takes a 16-bit hex value from the app-level display mux (result / cycle counter) and latches it tear-free at frame boundaries. Scans one digit at a time, with blanking dead-time to stop ghosting and optional leading-zero suppression. Sits directly downstream of the display-data mux and drives the anode/segment pins.

---
 rtl/seg7_scan_driver_pkg.sv | 31 +++
 rtl/seg7_scan_driver_hex_to_7segment.sv | 34 +++
 rtl/seg7_scan_driver.sv | 137 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// rtl/seg7_scan_driver_pkg.sv - shared scan state, pin polarity constants and blanking helper
//
// Purpose: types and constants shared by the 7-segment scan driver files.
//   scan_state_t   : per-slot phase (dead-time blank, then digit on)
//   ANODE_OFF      : all anodes released (active-low pins)
//   SEG_OFF        : all segments dark (active-high pins)
//   SEL_FIRST      : scan starts on the rightmost digit (digit4)
//   lz_suppress()  : leading-zero test for the digit picked by a one-hot selector
package seg7_scan_driver_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_t;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [6:0] SEG_OFF   = 7'b0000000;
  localparam logic [3:0] SEL_FIRST = 4'b0001;

  // A digit is a leading zero when its nibble and every nibble to its left
  // are zero. The rightmost digit (sel[0]) always shows, so "0" stays visible.
  function automatic logic lz_suppress(input logic [15:0] v, input logic [3:0] sel);
    logic res;
    res = 1'b0;
    if (sel[3])      res = (v[15:12] == 4'h0);
    else if (sel[2]) res = (v[15:8] == 8'h00);
    else if (sel[1]) res = (v[15:4] == 12'h000);
    return res;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_7segment.sv
// rtl/seg7_scan_driver_hex_to_7segment.sv - hex nibble to 7-segment glyph decoder
//
// Purpose: combinational glyph lookup for 0-F.
// Ports:
//   hex : input  [3:0] nibble to display
//   seg : output [6:0] {A,B,C,D,E,F,G}, active-high (1 = lit)
module hex_to_7segment (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b0000000;
    unique case (hex)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 4-digit common-anode 7-segment scan driver
//
// Purpose: shows a 16-bit hex value on four digits, one digit per slot,
// rightmost first. Each slot opens with a blanking dead-time to avoid ghosting.
// New values are captured into a pending register and only move to the
// displayed (shadow) copy at a frame boundary, so a frame never mixes two values.
// Ports:
//   clk         : system clock
//   reset       : asynchronous, active-low reset
//   value[15:0] : hex value, [15:12] = leftmost digit1, [3:0] = rightmost digit4
//   load        : 1-cycle strobe capturing value
//   lz_blank    : 1 = suppress leading zeros
//   digit_anode : active-low anodes, bit3 = digit1 .. bit0 = digit4
//   segments    : {A,B,C,D,E,F,G}, active-high
//   frame_tick  : 1-cycle pulse in the first cycle of each new frame
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SCAN_TICKS  = 120000,
  parameter int BLANK_TICKS = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lz_blank,
  output logic [3:0]  digit_anode,
  output logic [6:0]  segments,
  output logic        frame_tick
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [TW-1:0] SCAN_LAST  = TW'(SCAN_TICKS - 1);

  scan_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    sel_q, sel_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   pending_q, pending_d;
  logic          pflag_q, pflag_d;
  logic          frame_end;

  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic [3:0]    anode_d;
  logic [6:0]    seg_d;

  // The timer runs across the whole slot (blank + on), so the slot length is
  // SCAN_TICKS regardless of where the blank/on split falls.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    sel_d     = sel_q;
    frame_end = 1'b0;
    unique case (state_q)
      ST_BLANK: begin
        if (timer_q == BLANK_LAST) state_d = ST_ON;
      end
      ST_ON: begin
        if (timer_q == SCAN_LAST) begin
          state_d   = ST_BLANK;
          timer_d   = '0;
          sel_d     = {sel_q[2:0], sel_q[3]};
          frame_end = sel_q[3];
        end
      end
    endcase
  end

  // A load on the frame-end edge bypasses pending so it appears in the frame
  // that is just starting; otherwise the latest pending load is promoted.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    pflag_d   = pflag_q;
    if (frame_end) begin
      if (load)         shadow_d = value;
      else if (pflag_q) shadow_d = pending_q;
      pflag_d = 1'b0;
    end else if (load) begin
      pending_d = value;
      pflag_d   = 1'b1;
    end
  end

  // Outputs are computed from next-state values so the pins change on the
  // same edge as the state/selector they belong to.
  always_comb begin
    nibble = shadow_d[3:0];
    unique case (sel_d)
      4'b0010: nibble = shadow_d[7:4];
      4'b0100: nibble = shadow_d[11:8];
      4'b1000: nibble = shadow_d[15:12];
      default: nibble = shadow_d[3:0];
    endcase
  end

  hex_to_7segment u_hex (
    .hex (nibble),
    .seg (glyph)
  );

  always_comb begin
    anode_d = ANODE_OFF;
    seg_d   = SEG_OFF;
    if (state_d == ST_ON && !(lz_blank && lz_suppress(shadow_d, sel_d))) begin
      anode_d = ~sel_d;
      seg_d   = glyph;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_BLANK;
      timer_q     <= '0;
      sel_q       <= SEL_FIRST;
      shadow_q    <= '0;
      pending_q   <= '0;
      pflag_q     <= 1'b0;
      digit_anode <= ANODE_OFF;
      segments    <= SEG_OFF;
      frame_tick  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      sel_q       <= sel_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      pflag_q     <= pflag_d;
      digit_anode <= anode_d;
      segments    <= seg_d;
      frame_tick  <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int S = 8;
  localparam int B = 2;
  localparam int F = 4 * S;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        lz_blank;
  logic [3:0]  digit_anode;
  logic [6:0]  segments;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;

  seg7_scan_driver #(.SCAN_TICKS(S), .BLANK_TICKS(B)) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .load        (load),
    .lz_blank    (lz_blank),
    .digit_anode (digit_anode),
    .segments    (segments),
    .frame_tick  (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cycle index since reset release plus the value that the
  // current frame must show. Everything else follows by arithmetic.
  int          mc;
  logic [15:0] m_shadow;
  logic [15:0] m_pend;
  logic        m_pflag;
  logic        m_lz;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mc = 0; m_shadow = 0; m_pend = 0; m_pflag = 0; m_lz = 0;
    end else begin
      mc = mc + 1;
      m_lz = lz_blank;
      if (mc % F == 0) begin
        if (load) m_shadow = value;
        else if (m_pflag) m_shadow = m_pend;
        m_pflag = 0;
      end else if (load) begin
        m_pend = value;
        m_pflag = 1;
      end
    end
  end

  function automatic logic [6:0] glyph_of(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0: g = 7'b1111110; 4'h1: g = 7'b0110000; 4'h2: g = 7'b1101101; 4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011; 4'h5: g = 7'b1011011; 4'h6: g = 7'b1011111; 4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111; 4'h9: g = 7'b1111011; 4'hA: g = 7'b1110111; 4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110; 4'hD: g = 7'b0111101; 4'hE: g = 7'b1001111; default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  task automatic expect_out(output logic [3:0] an, output logic [6:0] sg, output logic tk);
    int pos, d;
    logic [15:0] upper;
    logic [3:0] one;
    logic sup;
    pos = mc % S;
    d = (mc / S) % 4;
    upper = m_shadow >> (4 * d);
    sup = m_lz && (d != 0) && (upper == 16'h0);
    one = 4'b0001;
    an = 4'b1111;
    sg = 7'b0000000;
    if (pos >= B && !sup) begin
      an = ~(one << d);
      sg = glyph_of(upper[3:0]);
    end
    tk = (mc > 0) && (mc % F == 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] ea;
    logic [6:0] es;
    logic et;
    if (reset) begin
      expect_out(ea, es, et);
      chk("cyc_anode", {28'b0, digit_anode}, {28'b0, ea});
      chk("cyc_segments", {25'b0, segments}, {25'b0, es});
      chk("cyc_frame_tick", {31'b0, frame_tick}, {31'b0, et});
      chk("anode_overlap", {31'b0, ($countones(~digit_anode) <= 1)}, 32'd1);
    end
  end

  task automatic wait_c(input int t);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((mc % F) != t && n < 100);
    if ((mc % F) != t) begin
      tests++;
      fails++;
      $display("FAIL wait_c: phase %0d not reached, at %0d", t, mc % F);
    end
  endtask

  task automatic check_at(input int t, input logic [3:0] an, input logic [6:0] sg, input string nm);
    wait_c(t);
    chk({nm, "_anode"}, {28'b0, digit_anode}, {28'b0, an});
    chk({nm, "_seg"}, {25'b0, segments}, {25'b0, sg});
  endtask

  task automatic load_pulse(input logic [15:0] v);
    load = 1'b1;
    value = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int ticks, last_tick;
    int lows [4];
    logic [3:0] ea;
    logic [6:0] es;

    reset = 1'b0; load = 1'b0; value = 16'h0; lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_anode", {28'b0, digit_anode}, 32'hF);
    chk("reset_seg", {25'b0, segments}, 32'h0);
    chk("reset_tick", {31'b0, frame_tick}, 32'h0);

    // 1: first slots after reset release
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (i >= 2 && i <= 7) begin ea = 4'b1110; es = 7'b1111110; end
      else if (i == 10) begin ea = 4'b1101; es = 7'b1111110; end
      else begin ea = 4'b1111; es = 7'b0000000; end
      chk($sformatf("t1_anode_c%0d", i), {28'b0, digit_anode}, {28'b0, ea});
      chk($sformatf("t1_seg_c%0d", i), {25'b0, segments}, {25'b0, es});
    end

    // 2: mid-frame load is deferred to the next frame
    wait_c(10);
    load_pulse(16'h1A2F);
    check_at(12, 4'b1101, 7'b1111110, "t2_old_d3");
    check_at(4, 4'b1110, 7'b1000111, "t2_d4");
    check_at(12, 4'b1101, 7'b1101101, "t2_d3");
    check_at(20, 4'b1011, 7'b1110111, "t2_d2");
    check_at(28, 4'b0111, 7'b0110000, "t2_d1");

    // 3: frame period and per-digit on time over three frames
    wait_c(0);
    ticks = 0; last_tick = 0;
    for (int k = 0; k < 4; k++) lows[k] = 0;
    for (int i = 1; i <= 3 * F; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        ticks++;
        chk("t3_tick_period", i - last_tick, F);
        last_tick = i;
      end
      for (int k = 0; k < 4; k++) if (!digit_anode[k]) lows[k]++;
    end
    chk("t3_tick_count", ticks, 3);
    for (int k = 0; k < 4; k++) chk($sformatf("t3_low_bit%0d", k), lows[k], 3 * (S - B));

    // 4: leading-zero suppression
    lz_blank = 1'b1;
    wait_c(5);
    load_pulse(16'h0008);
    check_at(4, 4'b1110, 7'b1111111, "t4a_d4");
    check_at(12, 4'b1111, 7'b0000000, "t4a_d3");
    check_at(20, 4'b1111, 7'b0000000, "t4a_d2");
    check_at(28, 4'b1111, 7'b0000000, "t4a_d1");
    wait_c(5);
    load_pulse(16'h0000);
    check_at(4, 4'b1110, 7'b1111110, "t4b_d4");
    check_at(12, 4'b1111, 7'b0000000, "t4b_d3");
    check_at(28, 4'b1111, 7'b0000000, "t4b_d1");
    wait_c(5);
    load_pulse(16'h0800);
    check_at(4, 4'b1110, 7'b1111110, "t4c_d4");
    check_at(12, 4'b1101, 7'b1111110, "t4c_d3");
    check_at(20, 4'b1011, 7'b1111111, "t4c_d2");
    check_at(28, 4'b1111, 7'b0000000, "t4c_d1");
    lz_blank = 1'b0;

    // 5: load on the frame-end edge, then another load two cycles later
    wait_c(F - 1);
    load_pulse(16'h00FF);
    wait_c(1);
    load_pulse(16'h0011);
    check_at(4, 4'b1110, 7'b1000111, "t5_first_d4");
    check_at(28, 4'b0111, 7'b1111110, "t5_first_d1");
    check_at(4, 4'b1110, 7'b0110000, "t5_second_d4");
    check_at(20, 4'b1011, 7'b1111110, "t5_second_d2");

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 15) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 63) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
    end
    @(negedge clk);
    load = 1'b0;
    lz_blank = 1'b0;
    wait_c(5);
    load_pulse(16'h5555);

    // 6: asynchronous reset mid-ON
    wait_c(4);
    wait_c(4);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_anode", {28'b0, digit_anode}, 32'hF);
    chk("t6_async_seg", {25'b0, segments}, 32'h0);
    chk("t6_async_tick", {31'b0, frame_tick}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_c1_anode", {28'b0, digit_anode}, 32'hF);
    @(posedge clk); #1;
    chk("t6_c2_anode", {28'b0, digit_anode}, 32'hE);
    chk("t6_c2_seg", {25'b0, segments}, {25'b0, 7'b1111110});
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
